// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE stream datapath.
//   pe_mux_mode_e : runtime select mode for pe_stream_mux
//   idx_wrap_inc  : modulo-n increment used by the RR pointer and arbiter scan
package pe_pkg;

  typedef enum logic {
    PE_MUX_FIXED = 1'b0,
    PE_MUX_RR    = 1'b1
  } pe_mux_mode_e;

  function automatic int unsigned idx_wrap_inc(input int unsigned idx,
                                               input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pe_rr_arbiter.sv
// Rotating-priority arbiter, purely combinational.
//   req     : request vector, one bit per channel
//   ptr     : channel with highest priority this cycle
//   gnt_idx : first requesting channel scanning ptr, ptr+1, ..., wrapping
//   gnt_vld : any request present
module pe_rr_arbiter
  import pe_pkg::*;
#(
  parameter int SEL_WIDTH = 3,
  localparam int N_IN     = 2 ** SEL_WIDTH
) (
  input  logic [N_IN-1:0]      req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] gnt_idx,
  output logic                 gnt_vld
);

  logic [SEL_WIDTH-1:0] cur;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cur     = ptr;
    for (int k = 0; k < N_IN; k++) begin
      if (!gnt_vld && req[cur]) begin
        gnt_vld = 1'b1;
        gnt_idx = cur;
      end
      cur = SEL_WIDTH'(idx_wrap_inc(int'(cur), N_IN));
    end
  end

endmodule

// File: rtl/pe_stream_mux.sv
// Registered N-to-1 stream multiplexer with per-channel valid/ready.
//   clk, rst         : clock, synchronous active-high reset
//   in_data/in_valid : per-channel beats; in_ready is combinational
//   mode, sel        : FIXED (take channel sel) or RR (rotating priority)
//   out_data/out_src : registered beat and the channel it came from
//   out_valid/ready  : one-deep output register handshake
module pe_stream_mux
  import pe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3,
  localparam int N_IN     = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data [0:N_IN-1],
  input  logic [N_IN-1:0]      in_valid,
  output logic [N_IN-1:0]      in_ready,
  input  logic                 mode,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  pe_mux_mode_e         mode_e;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] rr_idx, grant;
  logic                 rr_vld, grant_vld;
  logic                 load_en, xfer;
  logic [WIDTH-1:0]     data_q;
  logic [SEL_WIDTH-1:0] src_q;
  logic                 vld_q;

  assign mode_e = pe_mux_mode_e'(mode);

  pe_rr_arbiter #(.SEL_WIDTH(SEL_WIDTH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    if (mode_e == PE_MUX_RR) begin
      grant     = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant     = sel;
      grant_vld = in_valid[sel];
    end
  end

  // Register can take a new beat when empty or draining this edge.
  assign load_en = !vld_q || out_ready;
  assign xfer    = load_en && grant_vld && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  // Only RR transfers advance the pointer; FIXED traffic leaves it alone.
  assign ptr_d = (xfer && mode_e == PE_MUX_RR) ?
                 SEL_WIDTH'(idx_wrap_inc(int'(grant), N_IN)) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      src_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        data_q <= in_data[grant];
        src_q  <= grant;
        vld_q  <= 1'b1;
      end else if (out_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_pe_stream_mux.sv
module tb_pe_stream_mux;
  localparam int WIDTH = 8, SEL_WIDTH = 3, N_IN = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     in_data [0:N_IN-1];
  logic [N_IN-1:0]      in_valid, in_ready;
  logic                 mode;
  logic [SEL_WIDTH-1:0] sel;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_src;
  logic                 out_valid, out_ready;

  always #5 clk = ~clk;

  pe_stream_mux #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0]     d;
    logic [SEL_WIDTH-1:0] s;
  } beat_t;

  beat_t sbq[$];
  int n_tests = 0, n_fail = 0;

  // Reference model state: RR pointer and contents of the output register.
  int               m_ptr  = 0;
  bit               m_full = 0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_src  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every beat consumed downstream must match the
  // oldest beat the model saw accepted.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: unexpected beat data %0h src %0d", out_data, out_src);
      end else begin
        beat_t b;
        b = sbq.pop_front();
        chk("sb_data", 32'(out_data), 32'(b.d));
        chk("sb_src",  32'(out_src),  32'(b.s));
      end
    end
  end

  // One clock of stimulus; called at posedge+#1.
  task automatic step(input logic [N_IN-1:0] v, input logic md, input int sl,
                      input logic ordy, input logic r);
    int g;
    bit gv, xfer;
    logic [N_IN-1:0] er;
    beat_t b;
    in_valid = v; mode = md; sel = SEL_WIDTH'(sl); out_ready = ordy; rst = r;
    #1;
    gv = 0; g = 0;
    if (md) begin
      for (int k = 0; k < N_IN; k++) begin
        int i;
        i = (m_ptr + k) % N_IN;
        if (!gv && v[i]) begin gv = 1; g = i; end
      end
    end else begin
      g = sl; gv = v[sl];
    end
    xfer = !r && (!m_full || ordy) && gv;
    er = '0;
    if (xfer) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (r) begin
      sbq.delete(); m_full = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (xfer) begin
      b.d = in_data[g]; b.s = SEL_WIDTH'(g);
      sbq.push_back(b);
      m_full = 1; m_data = in_data[g]; m_src = g;
      if (md) m_ptr = (g + 1) % N_IN;
    end else if (ordy) begin
      m_full = 0;
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_src",   32'(out_src),   32'(m_src));
  endtask

  task automatic set_data(input int base);
    for (int i = 0; i < N_IN; i++) in_data[i] = WIDTH'(i + base);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    set_data(0);
    @(posedge clk); #1;
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);

    // FIXED sel=5, all valid
    set_data(8'h10);
    for (int c = 0; c < 5; c++) step('1, 0, 5, 1, 0);

    // RR with only channels 2 and 7: grants 2,7,2,7, pointer back to 0
    set_data(0);
    for (int c = 0; c < 4; c++) step(8'b1000_0100, 1, 0, 1, 0);

    // RR all valid, 10 beats: 0..7,0,1
    for (int c = 0; c < 10; c++) step('1, 1, 0, 1, 0);

    // Move pointer to 3, then FIXED sel=0 twice, then RR resumes at 3
    step(8'b0000_0100, 1, 0, 1, 0);
    step('1, 0, 0, 1, 0);
    step('1, 0, 0, 1, 0);
    step('1, 1, 0, 1, 0);

    // Backpressure: 3 stalled cycles then release with no bubble
    set_data(8'h40);
    step('1, 1, 0, 1, 0);
    for (int c = 0; c < 3; c++) step('1, 1, 0, 0, 0);
    step('1, 1, 0, 1, 0);
    step('1, 1, 0, 1, 0);

    // Reset mid-stream with a held beat, then lowest valid wins
    step('1, 1, 0, 1, 0);
    step('1, 1, 0, 0, 0);
    step('1, 1, 0, 0, 1);
    step(8'b0011_0000, 1, 0, 1, 0);
    step(8'b0011_0000, 1, 0, 1, 0);

    // Random stress
    for (int it = 0; it < 50; it++) begin
      for (int i = 0; i < N_IN; i++) in_data[i] = WIDTH'($urandom);
      step(N_IN'($urandom), 1'($urandom), int'($urandom_range(N_IN - 1, 0)),
           1'($urandom), 1'b0);
    end

    // Drain and confirm nothing was lost
    step('0, 1, 0, 1, 0);
    step('0, 1, 0, 1, 0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
